// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between a binary producer and the sequential BCD converter.
// The master drives the request and operand; the slave reports progress and the result.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one add-3 adjust plus one left shift per clock,
// WIDTH iterations per conversion, result held in bcd_out with a one-cycle done pulse.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [WIDTH-1:0]   bin_sr_reg;
  logic [WIDTH-1:0]   bin_sr_next;
  logic [BCD_W-1:0]   scratch_reg;
  logic [BCD_W-1:0]   scratch_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [BCD_W-1:0]   bcd_out_reg;
  logic [BCD_W-1:0]   bcd_out_next;

  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   shifted;
  logic               last_iter;
  logic               busy_comb;
  logic               done_comb;
  logic               unused_top_carry;

  // One add-3 cell per digit; inputs are always 0..9, so results stay in 0..12.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      logic [3:0] digit;
      assign digit                = scratch_reg[4*gi +: 4];
      assign adjusted[4*gi +: 4]  = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  endgenerate

  // The MSB shifted out of the top digit is discarded; DIGITS is sized so it is always zero.
  assign unused_top_carry = adjusted[BCD_W-1];
  assign shifted          = {adjusted[BCD_W-2:0], bin_sr_reg[WIDTH-1]};
  assign last_iter        = (cnt_reg == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = CONV;
      CONV:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_comb = 1'b0;
    done_comb = 1'b0;
    case (state_reg)
      CONV:    busy_comb = 1'b1;
      DONE:    done_comb = 1'b1;
      default: begin
        busy_comb = 1'b0;
        done_comb = 1'b0;
      end
    endcase
  end

  // Datapath: capture in IDLE, adjust-and-shift in CONV, publish on the last shift.
  always_comb begin
    bin_sr_next  = bin_sr_reg;
    scratch_next = scratch_reg;
    cnt_next     = cnt_reg;
    bcd_out_next = bcd_out_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          bin_sr_next  = bus.bin_in;
          scratch_next = '0;
          cnt_next     = CNT_W'(WIDTH);
        end
      end
      CONV: begin
        scratch_next = shifted;
        bin_sr_next  = {bin_sr_reg[WIDTH-2:0], 1'b0};
        cnt_next     = cnt_reg - CNT_W'(1);
        if (last_iter) begin
          bcd_out_next = shifted;
        end
      end
      default: begin
        bin_sr_next  = bin_sr_reg;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr_reg  <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      bcd_out_reg <= '0;
    end else begin
      bin_sr_reg  <= bin_sr_next;
      scratch_reg <= scratch_next;
      cnt_reg     <= cnt_next;
      bcd_out_reg <= bcd_out_next;
    end
  end

  assign bus.busy    = busy_comb;
  assign bus.done    = done_comb;
  assign bus.bcd_out = bcd_out_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases, exhaustive sweep with
// randomized post-capture operand changes, and request/reset corner cases.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [11:0] ref_bcd(input int n);
    logic [11:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a conversion from IDLE, scrambles bin_in right after capture, and
  // measures latency (cycles after acceptance until done), busy cycles and done width.
  task automatic do_conv(input logic [7:0] v, output logic [11:0] res, output int lat,
                         output int busy_cnt, output logic done_after);
    bus.start  = 1'b1;
    bus.bin_in = v;
    tick();
    bus.start  = 1'b0;
    bus.bin_in = 8'($urandom);
    lat        = 0;
    busy_cnt   = 0;
    res        = '0;
    done_after = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (bus.done) begin
        lat = k;
        res = bus.bcd_out;
        break;
      end
      if (bus.busy) busy_cnt++;
      tick();
    end
    if (lat != 0) begin
      tick();
      done_after = bus.done;
    end
    $display("conv bin=%0d bcd=%h lat=%0d busy=%0d", v, res, lat, busy_cnt);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.bin_in = 8'd77;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b bcd=%h want 0 0 000", bus.busy, bus.done, bus.bcd_out);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_discard busy=%b want 0", bus.busy);
    end
    $display("reset done");
  endtask

  task automatic test_directed();
    logic [7:0] vals [5];
    logic [11:0] res;
    int lat, bc;
    logic da;
    vals = '{8'd0, 8'd255, 8'd99, 8'd128, 8'd10};
    for (int i = 0; i < 5; i++) begin
      do_conv(vals[i], res, lat, bc, da);
      checks++;
      if (res !== ref_bcd(int'(vals[i]))) begin
        errors++;
        $display("FAIL directed_value bin=%0d got=%h want=%h", vals[i], res, ref_bcd(int'(vals[i])));
      end
      checks++;
      if (lat != WIDTH + 1 || bc != WIDTH || da !== 1'b0) begin
        errors++;
        $display("FAIL directed_timing bin=%0d lat=%0d busy=%0d done_after=%b want %0d %0d 0",
                 vals[i], lat, bc, da, WIDTH + 1, WIDTH);
      end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] res;
    int lat, bc;
    logic da;
    for (int n = 0; n < 256; n++) begin
      do_conv(8'(n), res, lat, bc, da);
      checks++;
      if (res !== ref_bcd(n) || lat != WIDTH + 1) begin
        errors++;
        $display("FAIL sweep bin=%0d got=%h lat=%0d want=%h lat=%0d", n, res, lat, ref_bcd(n), WIDTH + 1);
      end
    end
  endtask

  task automatic test_start_during_conv();
    int dones;
    logic [11:0] res, res2;
    int lat, bc;
    logic da;
    bus.start  = 1'b1;
    bus.bin_in = 8'd200;
    tick();
    bus.start  = 1'b0;
    tick();
    tick();
    bus.start  = 1'b1;
    bus.bin_in = 8'd7;
    tick();
    bus.start  = 1'b0;
    dones = 0;
    res   = '0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        dones++;
        res = bus.bcd_out;
      end
      tick();
    end
    $display("start_in_conv dones=%0d bcd=%h", dones, res);
    checks++;
    if (dones != 1 || res !== 12'h200) begin
      errors++;
      $display("FAIL start_in_conv dones=%0d bcd=%h want 1 200", dones, res);
    end
    do_conv(8'd7, res2, lat, bc, da);
    checks++;
    if (res2 !== ref_bcd(7)) begin
      errors++;
      $display("FAIL start_in_conv_next got=%h want=%h", res2, ref_bcd(7));
    end
  endtask

  task automatic test_held_start();
    int done_at [$];
    int busy_between;
    bus.start  = 1'b1;
    bus.bin_in = 8'd42;
    busy_between = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (bus.done) begin
        if (done_at.size() > 0) begin
          checks++;
          if (k - done_at[$] != WIDTH + 2 || busy_between != WIDTH) begin
            errors++;
            $display("FAIL held_period gap=%0d busy=%0d want %0d %0d",
                     k - done_at[$], busy_between, WIDTH + 2, WIDTH);
          end
        end
        checks++;
        if (bus.bcd_out !== 12'h042) begin
          errors++;
          $display("FAIL held_value got=%h want=042", bus.bcd_out);
        end
        $display("held done cycle=%0d bcd=%h", k, bus.bcd_out);
        done_at.push_back(k);
        busy_between = 0;
      end else if (bus.busy) begin
        busy_between++;
      end
    end
    checks++;
    if (done_at.size() < 3) begin
      errors++;
      $display("FAIL held_count dones=%0d want>=3", done_at.size());
    end
    bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.busy && !bus.done) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset_mid_conv();
    logic [11:0] res;
    int lat, bc, dones;
    logic da;
    do_conv(8'd123, res, lat, bc, da);
    checks++;
    if (res !== 12'h123) begin
      errors++;
      $display("FAIL midreset_prev got=%h want=123", res);
    end
    bus.start  = 1'b1;
    bus.bin_in = 8'd250;
    tick();
    bus.start  = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000) begin
      errors++;
      $display("FAIL midreset_state busy=%b done=%b bcd=%h want 0 0 000", bus.busy, bus.done, bus.bcd_out);
    end
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.done || bus.busy) dones++;
      tick();
    end
    $display("midreset activity=%0d", dones);
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midreset_quiet active_cycles=%0d want 0", dones);
    end
    do_conv(8'd250, res, lat, bc, da);
    checks++;
    if (res !== 12'h250) begin
      errors++;
      $display("FAIL midreset_restart got=%h want=250", res);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    test_reset();
    test_directed();
    test_sweep();
    test_start_during_conv();
    test_held_start();
    test_reset_mid_conv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
